// File: rtl/alu_shift_pkg.sv
// Shared types for the ALU shift datapath: shifter encodings,
// normalizer mode and normalizer FSM state encodings.
package alu_shift_pkg;

   typedef enum logic [2:0] {
      LL  = 3'b000,
      RL  = 3'b001,
      LA  = 3'b010,
      RA  = 3'b011,
      ROL = 3'b100,
      ROR = 3'b101
   } shift_type_e;

   typedef enum logic {
      UNSIGNED = 1'b0,
      SIGNED   = 1'b1
   } norm_mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      STEP = 2'd1,
      DONE = 2'd2
   } norm_state_e;

endpackage

// File: rtl/shift_normalizer64_if.sv
// Operand/result handshake bundle for the left-normalizer.
// master = producer/consumer side, slave = normalizer side.
interface shift_normalizer64_if #(
   parameter int WIDTH = 64
);
   localparam int CW = $clog2(WIDTH) + 1;

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_signed;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [CW-1:0]    out_count;
   logic             out_zero;

   modport master (
      output in_valid, in_data, in_signed, out_ready,
      input  in_ready, out_valid, out_data, out_count, out_zero
   );

   modport slave (
      input  in_valid, in_data, in_signed, out_ready,
      output in_ready, out_valid, out_data, out_count, out_zero
   );

endinterface

// File: rtl/shift_normalizer64_norm_stage.sv
// One binary-search normalization stage: shift left by k when the top
// k bits are zero (unsigned) or the top k+1 bits are equal (signed).
module norm_stage #(
   parameter int WIDTH = 64,
   parameter int SW    = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] value,
   input  logic [SW-1:0]    k,
   input  logic             is_signed,
   output logic [WIDTH-1:0] shifted,
   output logic             hit
);

   localparam logic [WIDTH-1:0] ONES = '1;

   logic [WIDTH-1:0] sign_diff;
   logic [WIDTH-1:0] check;
   logic [WIDTH-1:0] top_mask;

   // Bit i of sign_diff is 1 where bit i differs from bit i-1, so "top k+1
   // bits equal" becomes "top k bits of sign_diff are zero".
   always_comb begin
      sign_diff = value ^ {value[WIDTH-2:0], 1'b0};
      check     = is_signed ? sign_diff : value;
      top_mask  = ~(ONES >> k);
      hit       = ((check & top_mask) == '0);
      shifted   = hit ? (value << k) : value;
   end

endmodule

// File: rtl/shift_normalizer64.sv
// Iterative left-normalizer: one binary-search stage per clock, returns the
// normalized operand, the applied left-shift count and an all-zero flag.
//
//   state | meaning
//   IDLE  | ready for an operand; captures it on in_valid
//   STEP  | applies stage k = WIDTH/2 .. 1, one per cycle
//   DONE  | result held on outputs until out_ready
module shift_normalizer64
   import alu_shift_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input logic                clk,
   input logic                rst,
   shift_normalizer64_if.slave bus
);

   localparam int SW = $clog2(WIDTH);
   localparam int CW = SW + 1;

   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_STEP = STEP;
   localparam logic [1:0] S_DONE = DONE;

   localparam logic [SW-1:0] K_FIRST = SW'(WIDTH / 2);
   localparam logic [SW-1:0] IDX_LAST = SW'(SW - 1);

   logic [1:0]       state;
   logic [WIDTH-1:0] data_r;
   logic [CW-1:0]    cnt_r;
   logic             zero_r;
   norm_mode_e       mode_r;
   logic [SW-1:0]    idx_r;

   logic [SW-1:0]    k;
   logic             last;
   logic [WIDTH-1:0] stage_data;
   logic             stage_hit;

   assign k    = K_FIRST >> idx_r;
   assign last = (idx_r == IDX_LAST);

   norm_stage #(
      .WIDTH (WIDTH),
      .SW    (SW)
   ) u_stage (
      .value     (data_r),
      .k         (k),
      .is_signed (mode_r == SIGNED),
      .shifted   (stage_data),
      .hit       (stage_hit)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         data_r <= '0;
         cnt_r  <= '0;
         zero_r <= 1'b0;
         mode_r <= UNSIGNED;
         idx_r  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  data_r <= bus.in_data;
                  mode_r <= norm_mode_e'(bus.in_signed);
                  zero_r <= (bus.in_data == '0);
                  cnt_r  <= '0;
                  idx_r  <= '0;
                  state  <= S_STEP;
               end
            end
            S_STEP: begin
               data_r <= stage_data;
               idx_r  <= idx_r + 1'b1;
               // An unsigned zero has WIDTH leading zeros, one more than the stages can find.
               if (last && zero_r && (mode_r == UNSIGNED))
                  cnt_r <= CW'(WIDTH);
               else if (stage_hit)
                  cnt_r <= cnt_r + {1'b0, k};
               if (last)
                  state <= S_DONE;
            end
            S_DONE: begin
               if (bus.out_ready)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state == S_IDLE);
   assign bus.out_valid = (state == S_DONE);
   assign bus.out_data  = data_r;
   assign bus.out_count = cnt_r;
   assign bus.out_zero  = zero_r;

endmodule

// File: tb/tb_shift_normalizer64.sv
// Self-checking bench for shift_normalizer64: vector table through a
// scoreboard queue, plus backpressure, ignored-input and reset sequences.
module tb_shift_normalizer64;

   localparam int WIDTH = 64;

   typedef struct {
      logic [63:0] din;
      logic        sgn;
      logic [63:0] dout;
      logic [6:0]  cnt;
      logic        zero;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   shift_normalizer64_if #(.WIDTH(WIDTH)) bus ();

   shift_normalizer64 #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   vec_t vecs[13];
   vec_t sb[$];
   int   checks  = 0;
   int   errors  = 0;
   int   results = 0;

   always @(posedge clk)
      if (!rst && bus.out_valid && bus.out_ready) results++;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic start_op(input vec_t v, input bit push);
      int w = 0;
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.in_data   = v.din;
      bus.in_signed = v.sgn;
      while (!bus.in_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (w >= 20) chk("accept_timeout", 128'(w), 128'(0));
      @(posedge clk);
      if (push) sb.push_back(v);
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_signed = 1'b0;
   endtask

   task automatic finish_op(input int hold, input bit inject);
      int          n = 0;
      vec_t        e;
      logic [63:0] sd;
      logic [6:0]  sc;
      logic        sz;
      while (!bus.out_valid && n < 20) begin
         @(negedge clk);
         n++;
         if (inject && n == 2) begin
            chk("in_ready_in_step", 128'(bus.in_ready), 128'(0));
            bus.in_valid = 1'b1;
            bus.in_data  = 64'h1234;
         end else if (inject && n == 3) begin
            bus.in_valid = 1'b0;
            bus.in_data  = '0;
         end
      end
      chk("latency", 128'(n), 128'(6));
      if (sb.size() == 0) begin
         chk("scoreboard_underflow", 128'(0), 128'(1));
      end else begin
         e = sb.pop_front();
         chk("out_data", 128'(bus.out_data), 128'(e.dout));
         chk("out_count", 128'(bus.out_count), 128'(e.cnt));
         chk("out_zero", 128'(bus.out_zero), 128'(e.zero));
      end
      sd = bus.out_data;
      sc = bus.out_count;
      sz = bus.out_zero;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_outputs", {bus.out_valid, bus.in_ready, bus.out_data, bus.out_count, bus.out_zero},
             {1'b1, 1'b0, sd, sc, sz});
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk("post_handshake", {bus.in_ready, bus.out_valid}, {1'b1, 1'b0});
   endtask

   initial begin
      vec_t v;
      int   seen;

      vecs[0]  = '{64'h0000_0000_0000_0001, 1'b0, 64'h8000_0000_0000_0000, 7'd63, 1'b0};
      vecs[1]  = '{64'h0000_0000_0000_0000, 1'b0, 64'h0000_0000_0000_0000, 7'd64, 1'b1};
      vecs[2]  = '{64'h0000_0000_0000_0000, 1'b1, 64'h0000_0000_0000_0000, 7'd63, 1'b1};
      vecs[3]  = '{64'hFFFF_FFFF_FFFF_FF00, 1'b1, 64'h8000_0000_0000_0000, 7'd55, 1'b0};
      vecs[4]  = '{64'h8000_0000_0000_0000, 1'b0, 64'h8000_0000_0000_0000, 7'd0,  1'b0};
      vecs[5]  = '{64'h4000_0000_0000_0000, 1'b1, 64'h4000_0000_0000_0000, 7'd0,  1'b0};
      vecs[6]  = '{64'h2000_0000_0000_0000, 1'b1, 64'h4000_0000_0000_0000, 7'd1,  1'b0};
      vecs[7]  = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h8000_0000_0000_0000, 7'd63, 1'b0};
      vecs[8]  = '{64'h0000_0000_0001_0000, 1'b0, 64'h8000_0000_0000_0000, 7'd47, 1'b0};
      vecs[9]  = '{64'h00F0_0000_0000_0000, 1'b0, 64'hF000_0000_0000_0000, 7'd8,  1'b0};
      vecs[10] = '{64'h0000_0000_0000_0001, 1'b1, 64'h4000_0000_0000_0000, 7'd62, 1'b0};
      vecs[11] = '{64'hC000_0000_0000_0000, 1'b1, 64'h8000_0000_0000_0000, 7'd1,  1'b0};
      vecs[12] = '{64'h0000_0000_8000_0000, 1'b0, 64'h8000_0000_0000_0000, 7'd32, 1'b0};

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_signed = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_state", {bus.in_ready, bus.out_valid, bus.out_data, bus.out_count, bus.out_zero},
          {1'b1, 1'b0, 64'h0, 7'd0, 1'b0});

      for (int i = 0; i < 13; i++) begin
         start_op(vecs[i], 1'b1);
         finish_op(0, 1'b0);
      end

      // Backpressure: result held for 10 cycles with out_ready low.
      v = '{64'h0000_0000_0000_1234, 1'b0, 64'h91A0_0000_0000_0000, 7'd51, 1'b0};
      start_op(v, 1'b1);
      finish_op(10, 1'b0);

      // Operand offered mid-STEP must be ignored.
      v = '{64'h0000_0000_0000_0001, 1'b0, 64'h8000_0000_0000_0000, 7'd63, 1'b0};
      start_op(v, 1'b1);
      finish_op(0, 1'b1);
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.out_valid) seen++;
      end
      chk("no_extra_result", 128'(seen), 128'(0));

      // Reset during the third STEP cycle aborts the operation.
      v = '{64'h0000_0000_0000_00FF, 1'b0, 64'h0, 7'd0, 1'b0};
      start_op(v, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("reset_in_step", {bus.in_ready, bus.out_valid, bus.out_data, bus.out_count, bus.out_zero},
          {1'b1, 1'b0, 64'h0, 7'd0, 1'b0});
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.out_valid) seen++;
      end
      chk("aborted_no_result", 128'(seen), 128'(0));

      v = '{64'h0000_0000_0001_0000, 1'b0, 64'h8000_0000_0000_0000, 7'd47, 1'b0};
      start_op(v, 1'b1);
      finish_op(0, 1'b0);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 128'(sb.size()), 128'(0));
      chk("result_count", 128'(results), 128'(16));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/shift_normalizer64.md
# shift_normalizer64

Iterative left-normalizer: the inverse companion of the 64-bit barrel shifter. It takes an operand and discovers the left-shift amount that normalizes it. For unsigned operands that is the leading-zero count; for signed operands it is the redundant-sign-bit count. It returns both the normalized value and the count, so the shifter (or a later FP/divider datapath) can undo or reapply the shift. Sits on the ALU operand path behind a valid/ready handshake and resolves one binary-search stage per clock.

## Interface
Parameters:
- WIDTH, 64, operand width; power of two, at least 8
- CW, $clog2(WIDTH)+1, count width (7 at default); derived, not overridden

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand offered
- in_ready  out  1  block can accept an operand
- in_data  in  WIDTH  operand
- in_signed  in  1  0 = count leading zeros; 1 = count redundant sign bits
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_data  out  WIDTH  normalized operand
- out_count  out  CW  left-shift amount applied
- out_zero  out  1  operand was all-zero

## Operation
- FSM states:
  - IDLE: in_ready=1. When in_valid is high, capture in_data, in_signed and zero = (in_data==0); clear step index and count; go to STEP.
  - STEP: runs log2(WIDTH) cycles, with shift k = WIDTH/2, WIDTH/4, …, 1. Each cycle applies one stage:
    - unsigned: if the top k bits are all 0, shift left by k and add k to the count;
    - signed: if the top k+1 bits are all equal, shift left by k and add k to the count.
    - After the k=1 stage, go to DONE.
  - DONE: out_valid=1. When out_ready is high, go to IDLE.
- Unsigned zero operand: the stages run as normal (giving 63), then the result is forced to count = WIDTH (64) and out_zero=1. out_data = 0.
- Signed all-zero operand: count 63, out_data 0, out_zero=1.
- Signed all-ones operand: count 63, out_data 0x8000_0000_0000_0000, out_zero=0.
- Count arithmetic is unsigned CW-bit. The maximum is WIDTH, so it never wraps.
- Shifts are logical left with zero fill. Bits shifted out are always copies of the leading zeros or redundant sign bits, so no information is lost.
- in_valid outside IDLE is ignored; the operand is not captured. in_ready is low in STEP and DONE, so there is no overlap and no buffering.
- Outputs stay stable in DONE for as long as out_ready is low.
- Reset:
  - state → IDLE; in_ready=1, out_valid=0, out_data=0, out_count=0, out_zero=0.
  - Reset in STEP or DONE discards the operation; no result is produced.

## Timing
- Accept handshake: in_valid && in_ready at edge T.
- out_valid is high in the cycle after edge T+log2(WIDTH) (T+6 at default). Latency is fixed and independent of the data.
- Completion handshake: out_valid && out_ready at edge D. in_ready=1 in the cycle after D.
- A new operand can be accepted no earlier than edge D+1. Peak throughput is 1 result per 8 cycles at default.
- No combinational path from any input to any output. in_ready and out_valid are decoded from state registers only.

## Structure
- Shared package alu_shift_pkg holds:
  - shift_type_e: the 3-bit shifter encodings LL=000, RL=001, LA=010, RA=011, ROL=100, ROR=101;
  - norm_mode_e: UNSIGNED=0, SIGNED=1;
  - norm_state_e: IDLE, STEP, DONE.
- One combinational sub-module, norm_stage. Inputs: value, k, signed mode. Outputs: shifted value and a hit flag. Instantiated once and fed k from the step index; it is not unrolled, so area stays one stage.
- Top level: FSM, operand/count/zero registers and step counter.

## Test plan
- Unsigned 0x0000_0000_0000_0001 → out_data 0x8000_0000_0000_0000, out_count 63, out_zero 0. out_valid exactly 6 cycles after accept.
- Unsigned 0x0000_0000_0000_0000 → out_data 0, out_count 64, out_zero 1. Signed 0 → out_count 63, out_zero 1.
- Signed 0xFFFF_FFFF_FFFF_FF00 → out_data 0x8000_0000_0000_0000, out_count 55.
- Unsigned 0x8000_0000_0000_0000 → out_count 0, data unchanged. Signed 0x4000_0000_0000_0000 → out_count 0. Signed 0x2000_0000_0000_0000 → out_count 1, out_data 0x4000_0000_0000_0000.
- Backpressure and ignored input:
  - hold out_ready low 10 cycles in DONE → outputs constant and in_ready 0 throughout;
  - pulse in_valid during STEP with 0x1234 → that operand is never captured and only one result is produced.
- Reset asserted at cycle 3 of STEP → next cycle out_valid 0, in_ready 1, all outputs 0. A following operand 0x0000_0000_0001_0000 (unsigned) → out_count 47.
